adau_command_sequencer: RTL
===========================

# adau_command_sequencer

Parametrised successor of the fixed ADAU1761 init command list. It walks an external, synchronous-read command table and streams the table's commands to the SPI master over a valid/ready handshake. Table entries are SEND, WAIT or END opcodes. It raises `init_done` only once the SPI master is idle after the last command, and it can replay the table on request without a reset. It sits between the codec-config ROM and `spi_master` in the audio SoC.

## Interface
Parameters:
- `CMD_WIDTH`, 32: width of one SPI command word.
- `NUM_CMDS`, 16: table depth (entries); address width is `$clog2(NUM_CMDS)`.
- `DELAY_WIDTH`, 16: width of the WAIT cycle count; must satisfy `DELAY_WIDTH <= CMD_WIDTH`.

Ports:
- `clk`, in, 1: single clock; all logic on rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `table_addr`, out, `$clog2(NUM_CMDS)`: table read address.
- `table_data`, in, `CMD_WIDTH+2`: entry, valid one cycle after `table_addr`. Bits [CMD_WIDTH+1:CMD_WIDTH] are the opcode: 00 = SEND, 01 = WAIT, 1x = END. The low `CMD_WIDTH` bits are the payload.
- `command`, out, `CMD_WIDTH`: command to SPI master.
- `command_valid`, out, 1: `command` valid.
- `spi_ready`, in, 1: SPI master accepts the command / is idle.
- `start`, in, 1: single-cycle restart request.
- `busy`, out, 1: a sequence is in progress.
- `adau_init_done`, out, 1: sequence complete and SPI idle.

## Operation
- States: FETCH, DECODE, SEND, WAIT, DRAIN, DONE.
- Reset values: state FETCH; `table_addr` 0; `command` 0; `command_valid` 0; `busy` 1; `adau_init_done` 0; delay counter 0. The sequence starts automatically on reset release.
- FETCH: `table_addr` holds the current index. Go to DECODE on the next edge.
- DECODE: evaluate `table_data`.
  - SEND: register the payload into `command`, set `command_valid`, go to SEND.
  - WAIT: load the counter with payload[DELAY_WIDTH-1:0]. If the count is 0, increment the index and go to FETCH; otherwise go to WAIT.
  - END: go to DRAIN.
- SEND: hold `command` and `command_valid` stable while `spi_ready`=0. When an edge samples `command_valid`=1 and `spi_ready`=1, that is the handshake: clear `command_valid` and increment the index.
  - If the old index was `NUM_CMDS-1`, go to DRAIN (implicit END).
  - Otherwise go to FETCH.
- WAIT: decrement the counter each cycle. When it reaches 1, increment the index and go to FETCH, again with implicit END at `NUM_CMDS-1`. WAIT n spends exactly n cycles in the WAIT state.
- DRAIN: wait for an edge that samples `spi_ready`=1, then go to DONE with `adau_init_done`=1 and `busy`=0.
- DONE: outputs hold. On `start`=1: clear `adau_init_done`, set `busy`, reset the index to 0, go to FETCH.
- `start` outside DONE is ignored.
- Async reset asserted mid-sequence: all outputs go to reset values immediately, with no clock required. An in-flight command is dropped.

## Timing
- `command_valid` first rises after the 2nd rising edge following reset release (FETCH, then DECODE).
- Back-to-back SENDs with `spi_ready`=1: one command every 3 cycles (`command_valid` low for 2 cycles between commands).
- WAIT n between two SENDs: `command_valid` is low for n+4 cycles. WAIT 0: low for 4 cycles.
- `adau_init_done` rises on the first edge in DRAIN that samples `spi_ready`=1. It never rises while `spi_ready`=0.
- `start` sampled in DONE: `adau_init_done` falls on that edge; the first command is valid 2 edges later.

## Configuration
- `ADAU_SEQ_WAIT_EN` defined: the WAIT opcode behaves as described, and the counter and WAIT state are present.
- `ADAU_SEQ_WAIT_EN` undefined: the counter and WAIT state are removed. A WAIT entry is skipped, which is identical to WAIT 0: index increments, go to FETCH.

## Test plan
- Table {SEND 0x00000000 ×3, SEND 0x00400001, SEND 0x0040F9FF, END}, `spi_ready`=1 -> exactly these 5 commands in order. `adau_init_done`=0 until DRAIN, then 1.
- After 4 handshakes, hold `spi_ready`=0 for 100 cycles -> `command` stays 0x0040F9FF with `command_valid`=1 throughout. Raising `spi_ready` delivers it exactly once.
- Table {SEND A, WAIT 20, SEND B, END} -> `command_valid` low for exactly 24 cycles between A and B. With `ADAU_SEQ_WAIT_EN` undefined -> low for exactly 4 cycles.
- After the last handshake, hold `spi_ready`=0 for 10 cycles -> `adau_init_done` stays 0. Raise `spi_ready` -> `adau_init_done`=1 one edge later. NUM_CMDS=4 with no END entry -> done after the 4th SEND.
- In DONE, pulse `start` -> `adau_init_done` falls that edge and the full table replays identically. `start` pulsed mid-sequence -> no effect.
- Assert `reset` asynchronously mid-WAIT and mid-SEND -> `command_valid`, `adau_init_done` and `command` go to 0 before the next edge. Release -> sequence restarts from index 0.

Source files
------------

// File: rtl/adau_command_sequencer.sv
// adau_command_sequencer
//   Reads a synchronous-read command table and sends each SEND payload to the
//   SPI master over a valid/ready handshake. Table opcodes are SEND, WAIT and
//   END. adau_init_done is raised only after the SPI master reports idle
//   following the last command. A start pulse in DONE replays the table.
//
//   Optional feature macro: ADAU_SEQ_WAIT_EN
//     defined   -> WAIT entries stall for payload[DELAY_WIDTH-1:0] cycles
//     undefined -> no delay counter and no WAIT state; a WAIT entry is skipped
//                  and behaves exactly like WAIT 0
module adau_command_sequencer #(
  parameter int CMD_WIDTH   = 32,
  parameter int NUM_CMDS    = 16,
  parameter int DELAY_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  output logic [$clog2(NUM_CMDS)-1:0] table_addr,
  input  logic [CMD_WIDTH+1:0]        table_data,
  output logic [CMD_WIDTH-1:0]        command,
  output logic                        command_valid,
  input  logic                        spi_ready,
  input  logic                        start,
  output logic                        busy,
  output logic                        adau_init_done
);

  localparam int            AW       = $clog2(NUM_CMDS);
  localparam logic [AW-1:0] LAST_IDX = AW'(NUM_CMDS - 1);

  // The WAIT count is cut from the payload, so it cannot be wider than it.
  if (DELAY_WIDTH < 1 || DELAY_WIDTH > CMD_WIDTH) begin : g_bad_delay_width
    $error("adau_command_sequencer: DELAY_WIDTH must be in 1..CMD_WIDTH");
  end

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_SEND   = 3'd2,
`ifdef ADAU_SEQ_WAIT_EN
    S_WAIT   = 3'd3,
`endif
    S_DRAIN  = 3'd4,
    S_DONE   = 3'd5
  } state_e;

  state_e                 state_q, state_d;
  logic [AW-1:0]          idx_q, idx_d;
  logic [CMD_WIDTH-1:0]   command_q, command_d;
  logic                   valid_q, valid_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
`ifdef ADAU_SEQ_WAIT_EN
  logic [DELAY_WIDTH-1:0] cnt_q, cnt_d;
`endif

  logic [1:0]           opcode;
  logic [CMD_WIDTH-1:0] payload;
  logic [AW-1:0]        idx_inc;
  state_e               adv_state;

  assign opcode  = table_data[CMD_WIDTH+1:CMD_WIDTH];
  assign payload = table_data[CMD_WIDTH-1:0];
  assign idx_inc = idx_q + AW'(1);
  // The last table slot is an implicit END: leaving it always drains.
  assign adv_state = (idx_q == LAST_IDX) ? S_DRAIN : S_FETCH;

  // Next-state and next-output computation for the sequencer FSM.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    command_d = command_q;
    valid_d   = valid_q;
    busy_d    = busy_q;
    done_d    = done_q;
`ifdef ADAU_SEQ_WAIT_EN
    cnt_d     = cnt_q;
`endif
    case (state_q)
      S_FETCH: state_d = S_DECODE;

      S_DECODE: begin
        if (opcode[1]) begin
          state_d = S_DRAIN;
        end else if (!opcode[0]) begin
          command_d = payload;
          valid_d   = 1'b1;
          state_d   = S_SEND;
        end else begin
`ifdef ADAU_SEQ_WAIT_EN
          cnt_d = payload[DELAY_WIDTH-1:0];
          if (payload[DELAY_WIDTH-1:0] == '0) begin
            idx_d   = idx_inc;
            state_d = adv_state;
          end else begin
            state_d = S_WAIT;
          end
`else
          idx_d   = idx_inc;
          state_d = adv_state;
`endif
        end
      end

      // command/command_valid are held until the SPI master takes the word.
      S_SEND: begin
        if (spi_ready) begin
          valid_d = 1'b0;
          idx_d   = idx_inc;
          state_d = adv_state;
        end
      end

`ifdef ADAU_SEQ_WAIT_EN
      // Leaving on a count of 1 makes WAIT n occupy exactly n cycles here.
      S_WAIT: begin
        cnt_d = cnt_q - DELAY_WIDTH'(1);
        if (cnt_q == DELAY_WIDTH'(1)) begin
          idx_d   = idx_inc;
          state_d = adv_state;
        end
      end
`endif

      // Last word may still be shifting out; done only once SPI is idle.
      S_DRAIN: begin
        if (spi_ready) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        if (start) begin
          done_d  = 1'b0;
          busy_d  = 1'b1;
          idx_d   = '0;
          state_d = S_FETCH;
        end
      end

      default: state_d = S_FETCH;
    endcase
  end

  // State and registered outputs; async reset drops any in-flight command.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      idx_q     <= '0;
      command_q <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b1;
      done_q    <= 1'b0;
`ifdef ADAU_SEQ_WAIT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      command_q <= command_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef ADAU_SEQ_WAIT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign table_addr     = idx_q;
  assign command        = command_q;
  assign command_valid  = valid_q;
  assign busy           = busy_q;
  assign adau_init_done = done_q;

endmodule
